mem_responder: RTL and testbench

//   Memory-side responder for the CPU control unit's bus strobes (read/membus, write/busmem).

---
 rtl/mem_responder.sv | 141 ++++++++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: CPU bus reads/writes in RUN, front-panel program entry (IN)
// and memory inspection (CHECK) driven by a synchronized step button.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cpustate_i,
  input  logic [15:0]       addr_i,
  input  logic              read_i,
  input  logic              membus_i,
  input  logic              write_i,
  input  logic              busmem_i,
  input  logic [DATA_W-1:0] bus_in_i,
  output logic [DATA_W-1:0] bus_out_o,
  output logic              bus_oe_o,
  input  logic [DATA_W-1:0] sw_data_i,
  input  logic              sw_step_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [DATA_W-1:0] chk_data_o,
  output logic              load_full_o,
  output logic              err_oob_o,
  output logic              err_rw_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_IN    = 2'b01;
  localparam logic [1:0] ST_CHECK = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [1:0]        state_q;
  logic              sync1_q, sync2_q, sync3_q, step_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] chk_data_q;
  logic              load_full_q, load_full_d;
  logic              err_oob_q, err_oob_d;
  logic              err_rw_q, err_rw_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic run, in_mode, chk_mode, entering, step_fire;
  logic rd_req, wr_req, oob, rw_clash;
  logic [ADDR_W-1:0] cpu_addr;

  assign run      = (cpustate_i == ST_RUN);
  assign in_mode  = (cpustate_i == ST_IN);
  assign chk_mode = (cpustate_i == ST_CHECK);
  assign entering = (in_mode || chk_mode) && (state_q != cpustate_i);
  assign step_fire = step_q && !entering;

  assign rd_req   = read_i && membus_i;
  assign wr_req   = write_i && busmem_i;
  assign rw_clash = read_i && write_i;
  assign oob      = |(addr_i >> ADDR_W);
  assign cpu_addr = addr_i[ADDR_W-1:0];

  // Step button: two-flop synchronizer, edge flop, registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= sw_step_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      step_q  <= sync2_q && !sync3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      chk_data_q  <= '0;
      load_full_q <= 1'b0;
      err_oob_q   <= 1'b0;
      err_rw_q    <= 1'b0;
    end else begin
      state_q     <= cpustate_i;
      ptr_q       <= ptr_d;
      chk_data_q  <= mem[ptr_q];
      load_full_q <= load_full_d;
      err_oob_q   <= err_oob_d;
      err_rw_q    <= err_rw_d;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    load_full_d = load_full_q;
    err_oob_d   = err_oob_q;
    err_rw_d    = err_rw_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = sw_data_i;
    if (entering) begin
      ptr_d = '0;
    end else if (step_fire && in_mode) begin
      mem_we = 1'b1;
      ptr_d  = ptr_q + 1'b1;
      if (ptr_q == PTR_MAX) load_full_d = 1'b1;
    end else if (step_fire && chk_mode) begin
      ptr_d = ptr_q + 1'b1;
    end
    if (run) begin
      if ((rd_req || wr_req) && oob) err_oob_d = 1'b1;
      if (rw_clash) err_rw_d = 1'b1;
      if (wr_req && !oob && !rw_clash) begin
        mem_we    = 1'b1;
        mem_waddr = cpu_addr;
        mem_wdata = bus_in_i;
      end
    end
  end

  // RAM is never cleared; a write coinciding with reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    bus_oe_o  = rst_n && run && rd_req;
    bus_out_o = '0;
    if (bus_oe_o && !oob) bus_out_o = mem[cpu_addr];
  end

  assign ptr_o       = ptr_q;
  assign chk_data_o  = chk_data_q;
  assign load_full_o = load_full_q;
  assign err_oob_o   = err_oob_q;
  assign err_rw_o    = err_rw_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: panel entry/inspection, RUN bus access, error flags, reset.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cpustate;
  logic [15:0] addr;
  logic        read, membus, write, busmem;
  logic [7:0]  bus_in, bus_out, sw_data, chk_data;
  logic        bus_oe, sw_step, load_full, err_oob, err_rw;
  logic [7:0]  ptr;

  int checks = 0;
  int failures = 0;

  mem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpustate_i(cpustate), .addr_i(addr),
    .read_i(read), .membus_i(membus), .write_i(write), .busmem_i(busmem),
    .bus_in_i(bus_in), .bus_out_o(bus_out), .bus_oe_o(bus_oe),
    .sw_data_i(sw_data), .sw_step_i(sw_step), .ptr_o(ptr), .chk_data_o(chk_data),
    .load_full_o(load_full), .err_oob_o(err_oob), .err_rw_o(err_rw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_btn();
    sw_step = 1'b1;
    repeat (5) tick();
    sw_step = 1'b0;
    repeat (5) tick();
  endtask

  task automatic cpu_idle();
    read = 0; membus = 0; write = 0; busmem = 0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
    addr = a; read = 1; membus = 1;
    #1;
    check(tag, {8'h00, bus_out}, {8'h00, exp});
    check({tag, "_oe"}, {15'h0, bus_oe}, 16'h1);
    tick();
    cpu_idle();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; bus_in = d; write = 1; busmem = 1;
    tick();
    cpu_idle();
  endtask

  initial begin
    rst_n = 0; cpustate = 2'b00; addr = 0; bus_in = 0; sw_data = 0; sw_step = 0;
    cpu_idle();
    repeat (2) tick();
    check("rst_ptr", {8'h0, ptr}, 16'h0);
    check("rst_chk", {8'h0, chk_data}, 16'h0);
    check("rst_flags", {13'h0, load_full, err_oob, err_rw}, 16'h0);
    check("rst_oe", {15'h0, bus_oe}, 16'h0);
    rst_n = 1;
    tick();

    // Program entry
    cpustate = 2'b01;
    tick();
    check("in_entry_ptr", {8'h0, ptr}, 16'h0);
    sw_data = 8'h11; step_btn();
    sw_data = 8'h22; step_btn();
    sw_data = 8'h33; step_btn();
    check("in_ptr3", {8'h0, ptr}, 16'h3);
    check("in_full0", {15'h0, load_full}, 16'h0);

    // Inspection
    cpustate = 2'b10;
    tick();
    check("chk_entry_ptr", {8'h0, ptr}, 16'h0);
    tick();
    check("chk_data0", {8'h0, chk_data}, 16'h11);
    step_btn();
    check("chk_ptr1", {8'h0, ptr}, 16'h1);
    check("chk_data1", {8'h0, chk_data}, 16'h22);

    // Strobes ignored outside RUN
    addr = 16'h0001; read = 1; membus = 1;
    #1;
    check("norun_oe", {15'h0, bus_oe}, 16'h0);
    check("norun_out", {8'h0, bus_out}, 16'h0);
    cpu_idle();

    // RUN accesses
    cpustate = 2'b11;
    tick();
    cpu_read(16'h0001, 8'h22, "run_rd1");
    cpu_write(16'h0002, 8'h5A);
    cpu_read(16'h0002, 8'h5A, "run_rd2");
    check("oob_clear", {15'h0, err_oob}, 16'h0);
    cpu_read(16'h0100, 8'h00, "oob_rd");
    check("oob_flag", {15'h0, err_oob}, 16'h1);
    cpu_write(16'h0100, 8'h77);
    cpu_read(16'h0000, 8'h11, "oob_nowr");

    // Fill all 256 locations, mem[i] = i
    cpustate = 2'b01;
    tick();
    for (int i = 0; i < 255; i++) begin
      sw_data = 8'(i);
      step_btn();
    end
    check("fill_ptr255", {8'h0, ptr}, 16'h00FF);
    check("fill_full0", {15'h0, load_full}, 16'h0);
    sw_data = 8'hFF;
    step_btn();
    check("wrap_ptr", {8'h0, ptr}, 16'h0);
    check("wrap_full", {15'h0, load_full}, 16'h1);

    // Simultaneous read and write
    cpustate = 2'b11;
    tick();
    addr = 16'h0003; bus_in = 8'hEE; read = 1; membus = 1; write = 1; busmem = 1;
    #1;
    check("rw_rd", {8'h0, bus_out}, 16'h0003);
    tick();
    cpu_idle();
    check("rw_flag", {15'h0, err_rw}, 16'h1);
    cpu_read(16'h0003, 8'h03, "rw_nowr");
    cpu_read(16'h00FF, 8'hFF, "fill_last");

    // Reset with a step pulse in flight
    cpustate = 2'b01;
    tick();
    sw_data = 8'hAB;
    step_btn();
    check("pre_rst_ptr", {8'h0, ptr}, 16'h1);
    sw_data = 8'hCD;
    sw_step = 1;
    repeat (2) tick();
    rst_n = 0;
    #1;
    check("mid_rst_ptr", {8'h0, ptr}, 16'h0);
    check("mid_rst_flags", {13'h0, load_full, err_oob, err_rw}, 16'h0);
    sw_step = 0;
    repeat (3) tick();
    rst_n = 1;
    cpustate = 2'b11;
    tick();
    cpu_read(16'h0000, 8'hAB, "ram_kept0");
    cpu_read(16'h0001, 8'h01, "ram_kept1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
